// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter (ALU = A, load unit = B) with a one-cycle registered write port.
// Optional macro STARVE_GUARD_EN adds a saturating B-starvation counter that forces a B grant when it saturates.
module regfile_write_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [1:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [1:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [1:0]        wr,
  output logic [DATA_W-1:0] wd,
  output logic              regwrite,
  output logic              r0_drop
);

  logic              starve;
  logic              a_fire;
  logic              b_fire;
  logic [1:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        wr_p1;
  logic [DATA_W-1:0] wd_p1;
  logic              vld_p1;
  logic              drop_p1;

`ifdef STARVE_GUARD_EN
  logic [1:0] starve_cnt_p1;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  assign starve = (starve_cnt_p1 == 2'd3);

  // Counts cycles B waits while valid; any B fire or B going idle clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_p1 <= 2'd0;
    end else if (b_valid && !b_ready) begin
      starve_cnt_p1 <= sat_inc(starve_cnt_p1);
    end else begin
      starve_cnt_p1 <= 2'd0;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset) begin
      if (a_valid && b_valid) begin
        if (starve) b_ready = 1'b1;
        else        a_ready = 1'b1;
      end else if (a_valid) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  assign a_fire   = a_valid && a_ready;
  assign b_fire   = b_valid && b_ready;
  assign sel_addr = b_fire ? b_addr : a_addr;
  assign sel_data = b_fire ? b_data : a_data;

  // Stage p0 -> p1: register the granted write; address 0 becomes a drop pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_p1   <= 2'd0;
      wd_p1   <= '0;
      vld_p1  <= 1'b0;
      drop_p1 <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      drop_p1 <= 1'b0;
      if (a_fire || b_fire) begin
        wr_p1   <= sel_addr;
        wd_p1   <= sel_data;
        vld_p1  <= (sel_addr != 2'd0);
        drop_p1 <= (sel_addr == 2'd0);
      end
    end
  end

  assign wr       = wr_p1;
  assign wd       = wd_p1;
  assign regwrite = vld_p1;
  assign r0_drop  = drop_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a rule-level reference model; honours STARVE_GUARD_EN.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic [1:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [1:0]  wr;
  logic [15:0] wd;
  logic        regwrite, r0_drop;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int          m_wait;      // consecutive cycles B has waited
  logic [1:0]  m_wr;
  logic [15:0] m_wd;
  logic        m_rw, m_drop;
  logic        m_ga, m_gb;  // model grant of the last step
  logic        o_ga, o_gb;  // DUT readies observed in the last step

`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  regfile_write_arbiter #(.DATA_W(16)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr(wr), .wd(wd), .regwrite(regwrite), .r0_drop(r0_drop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check readies against the rules, then check the registered outputs.
  task automatic step();
    #1;
    m_ga = 1'b0;
    m_gb = 1'b0;
    if (!reset) begin
      if (a_valid && b_valid) begin
        if (GUARD && m_wait >= 3) m_gb = 1'b1;
        else                      m_ga = 1'b1;
      end else begin
        m_ga = a_valid;
        m_gb = b_valid;
      end
    end
    o_ga = a_ready;
    o_gb = b_ready;
    chk("a_ready", a_ready, m_ga);
    chk("b_ready", b_ready, m_gb);
    @(posedge clock);
    #1;
    if (reset) begin
      m_wr = 0; m_wd = 0; m_rw = 0; m_drop = 0; m_wait = 0;
    end else begin
      m_rw = 0; m_drop = 0;
      if (m_ga || m_gb) begin
        m_wr   = m_gb ? b_addr : a_addr;
        m_wd   = m_gb ? b_data : a_data;
        m_rw   = (m_wr != 0);
        m_drop = (m_wr == 0);
      end
      if (b_valid && !m_gb) m_wait = (m_wait < 3) ? m_wait + 1 : 3;
      else                  m_wait = 0;
    end
    chk("wr", wr, m_wr);
    chk("wd", wd, m_wd);
    chk("regwrite", regwrite, m_rw);
    chk("r0_drop", r0_drop, m_drop);
  endtask

  task automatic do_reset();
    reset = 1'b1; a_valid = 0; b_valid = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    m_wait = 0; m_wr = 0; m_wd = 0; m_rw = 0; m_drop = 0;
    do_reset();
    chk("rst_regwrite", regwrite, 0);
    chk("rst_wd", wd, 0);

    // single A write then idle
    a_valid = 1; a_addr = 2; a_data = 16'h1234;
    step();
    chk("r031_wr", wr, 2);
    chk("r031_wd", wd, 16'h1234);
    chk("r031_rw", regwrite, 1);
    a_valid = 0;
    step();
    chk("r031_idle_rw", regwrite, 0);
    chk("r031_hold_wd", wd, 16'h1234);

    // both valid, A first then B
    a_valid = 1; a_addr = 1; a_data = 16'hAAAA;
    b_valid = 1; b_addr = 3; b_data = 16'h5555;
    step();
    chk("r032_wr0", wr, 1);
    chk("r032_wd0", wd, 16'hAAAA);
    chk("r032_rw0", regwrite, 1);
    a_valid = 0;
    step();
    chk("r032_wr1", wr, 3);
    chk("r032_wd1", wd, 16'h5555);
    chk("r032_rw1", regwrite, 1);
    b_valid = 0;
    step();

    // write to r0 is dropped
    b_valid = 1; b_addr = 0; b_data = 16'hFFFF;
    step();
    chk("r033_rw", regwrite, 0);
    chk("r033_drop", r0_drop, 1);
    chk("r033_wd", wd, 16'hFFFF);
    b_valid = 0;
    step();
    chk("r033_drop_clr", r0_drop, 0);

    // six cycles of contention
    do_reset();
    a_valid = 1; a_addr = 1; a_data = 16'h0A0A;
    b_valid = 1; b_addr = 2; b_data = 16'h0B0B;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("r034_b_grant", o_gb, (GUARD && i == 3) ? 1 : 0);
      chk("r034_a_grant", o_ga, (GUARD && i == 3) ? 0 : 1);
    end
    a_valid = 0; b_valid = 0;
    step();

    // reset while both valid
    a_valid = 1; a_addr = 3; a_data = 16'h7777;
    b_valid = 1; b_addr = 1; b_data = 16'h8888;
    reset = 1;
    step();
    chk("r035_a_ready", o_ga, 0);
    chk("r035_b_ready", o_gb, 0);
    chk("r035_rw", regwrite, 0);
    chk("r035_wr", wr, 0);
    chk("r035_wd", wd, 0);
    reset = 0;
    step();
    chk("r035_a_grant", o_ga, 1);
    chk("r035_wd_after", wd, 16'h7777);

    // randomized traffic with occasional reset; requesters hold until accepted
    for (int n = 0; n < 500; n++) begin
      if (!(a_valid && !m_ga)) begin
        a_valid = ($urandom_range(0, 99) < 70);
        a_addr  = 2'($urandom_range(0, 3));
        a_data  = 16'($urandom);
      end
      if (!(b_valid && !m_gb)) begin
        b_valid = ($urandom_range(0, 99) < 75);
        b_addr  = 2'($urandom_range(0, 3));
        b_data  = 16'($urandom);
      end
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 0; a_valid = 0; b_valid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
